// File: rtl/cla_add_pipe_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder:
// group width, 4-bit lookahead carry equations and stage slice arithmetic.
package cla_pkg;

    localparam int GROUP_W = 4;

    // Bit i of the result is the carry out of bit i, i.e. c[i+1].
    function automatic logic [GROUP_W-1:0] cla_carries(input logic [GROUP_W-1:0] g,
                                                      input logic [GROUP_W-1:0] p,
                                                      input logic             ci);
        logic [GROUP_W-1:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic int stage_lo(input int k, input int gps);
        return k * GROUP_W * gps;
    endfunction

    function automatic int nstage(input int width, input int gps);
        return width / (GROUP_W * gps);
    endfunction

endpackage

// File: rtl/cla_add_pipe_if.sv
// Operation/result handshake bundle for cla_add_pipe.
interface cla_add_pipe_if #(parameter int WIDTH = 16);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cIn;
    logic             sub;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] s;
    logic             cOut;
    logic             ovf;

    modport master (output inValid, x, y, cIn, sub, outReady,
                    input  inReady, outValid, s, cOut, ovf);
    modport slave  (input  inValid, x, y, cIn, sub, outReady,
                    output inReady, outValid, s, cOut, ovf);
endinterface

// File: rtl/cla_add_pipe_group4.sv
// Combinational 4-bit carry-lookahead group; c3 is the carry into bit 3.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cIn,
    output logic [GROUP_W-1:0] s,
    output logic               cOut,
    output logic               c3
);
    logic [GROUP_W-1:0] g, p, c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c    = cla_carries(g, p, cIn);
    assign s    = p ^ {c[2:0], cIn};
    assign cOut = c[3];
    assign c3   = c[2];
endmodule

// File: rtl/cla_add_pipe.sv
// Pipelined carry-lookahead adder/subtractor: GPS lookahead groups per stage,
// carry and unconsumed operand bits registered between stages, global stall.
module cla_add_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int GPS   = 1
) (
    input logic           clk,
    input logic           rstN,
    cla_add_pipe_if.slave bus
);
    localparam int SL     = GROUP * GPS;
    localparam int NSTAGE = nstage(WIDTH, GPS);

    logic adv;
    logic out_vld;
    logic ovf_d, ovf_q;

    // The whole pipeline advances together or holds together.
    assign adv = !out_vld || bus.outReady;

    genvar k, j;
    for (k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int LO = stage_lo(k, GPS);
        localparam int AW = WIDTH - LO;

        logic [AW-1:0]      a_in, b_in;
        logic               c_in, v_in;
        logic [GPS:0]       gc;
        logic [SL-1:0]      s_sl;
        logic [LO+SL-1:0]   sum_d, sum_q;
        logic               vld_q, c_q;

        if (k == 0) begin : g_in
            // Subtraction is folded in here once; later stages only add.
            assign a_in  = bus.x;
            assign b_in  = bus.y ^ {WIDTH{bus.sub}};
            assign c_in  = bus.cIn ^ bus.sub;
            assign v_in  = bus.inValid;
            assign sum_d = s_sl;
        end else begin : g_mid
            assign a_in  = g_stg[k-1].g_hold.a_q;
            assign b_in  = g_stg[k-1].g_hold.b_q;
            assign c_in  = g_stg[k-1].c_q;
            assign v_in  = g_stg[k-1].vld_q;
            assign sum_d = {s_sl, g_stg[k-1].sum_q};
        end

        assign gc[0] = c_in;
        for (j = 0; j < GPS; j++) begin : g_grp
            logic c3;
            cla_group4 u_grp (
                .a    (a_in[j*GROUP +: GROUP]),
                .b    (b_in[j*GROUP +: GROUP]),
                .cIn  (gc[j]),
                .s    (s_sl[j*GROUP +: GROUP]),
                .cOut (gc[j+1]),
                .c3   (c3)
            );
        end

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= v_in;
                c_q   <= gc[GPS];
                sum_q <= sum_d;
            end
        end

        if (k < NSTAGE - 1) begin : g_hold
            logic [AW-SL-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[AW-1:SL];
                    b_q <= b_in[AW-1:SL];
                end
            end
        end
    end

    // Overflow needs the carry into the MSB, only available in the last stage.
    assign ovf_d = g_stg[NSTAGE-1].g_grp[GPS-1].c3 ^ g_stg[NSTAGE-1].gc[GPS];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_vld      = g_stg[NSTAGE-1].vld_q;
    assign bus.outValid = out_vld;
    assign bus.inReady  = adv;
    assign bus.s        = g_stg[NSTAGE-1].sum_q;
    assign bus.cOut     = g_stg[NSTAGE-1].c_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_cla_add_pipe.sv
// Bench for cla_add_pipe: directed corner cases, stall and reset scenarios on a
// 16-bit/GPS=1 instance, then random traffic on it and a 32-bit/GPS=4 instance.
module tb_cla_add_pipe;
    localparam int W0 = 16, G0 = 1, N0 = 4;
    localparam int W1 = 32, G1 = 4, N1 = 2;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    cla_add_pipe_if #(.WIDTH(W0)) if0();
    cla_add_pipe_if #(.WIDTH(W1)) if1();

    cla_add_pipe #(.WIDTH(W0), .GROUP(4), .GPS(G0)) dut0 (.clk(clk), .rstN(rstN), .bus(if0));
    cla_add_pipe #(.WIDTH(W1), .GROUP(4), .GPS(G1)) dut1 (.clk(clk), .rstN(rstN), .bus(if1));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stalls [2];
    logic [65:0] expq [2][$];
    int          accq [2][$];
    int          stq  [2][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: {ovf, cOut, s} from integer add/subtract.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] x, input logic [63:0] y,
                                           input logic ci, input logic sb);
        longint mod, ux, uy, sx, sy, c, ur, sr;
        logic co, ov;
        logic [63:0] s;
        mod = longint'(1) <<< w;
        ux  = longint'(x);
        uy  = longint'(y);
        c   = ci ? 1 : 0;
        sx  = (ux >= mod / 2) ? ux - mod : ux;
        sy  = (uy >= mod / 2) ? uy - mod : uy;
        if (!sb) begin
            ur = ux + uy + c;
            sr = sx + sy + c;
            co = (ur >= mod);
        end else begin
            ur = ux - uy - c;
            sr = sx - sy - c;
            co = (ur >= 0);
        end
        ov = (sr >= mod / 2) || (sr < -(mod / 2));
        s  = 64'(ur & (mod - 1));
        return {ov, co, s};
    endfunction

    task automatic observe(input int d, input int nst, input int w,
                           input logic iv, input logic ir, input logic ov, input logic ordy,
                           input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb,
                           input logic [63:0] s, input logic co, input logic of);
        logic [65:0] e;
        int a, st;
        if (ov && ordy) begin
            checks++;
            assert (expq[d].size() > 0) else begin
                errors++;
                $error("FAIL d%0d_unexpected_result observed=0x%0h expected=none", d, s);
            end
            if (expq[d].size() > 0) begin
                e  = expq[d].pop_front();
                a  = accq[d].pop_front();
                st = stq[d].pop_front();
                chk($sformatf("d%0d_s", d),    s, e[63:0]);
                chk($sformatf("d%0d_cOut", d), 64'(co), 64'(e[64]));
                chk($sformatf("d%0d_ovf", d),  64'(of), 64'(e[65]));
                chk($sformatf("d%0d_latency", d), 64'(cyc - a - (stalls[d] - st)), 64'(nst));
            end
        end
        if (ov && !ordy) stalls[d]++;
        if (iv && ir) begin
            expq[d].push_back(ref_op(w, x, y, ci, sb));
            accq[d].push_back(cyc);
            stq[d].push_back(stalls[d]);
        end
    endtask

    task automatic sample();
        cyc++;
        observe(0, N0, W0, if0.inValid, if0.inReady, if0.outValid, if0.outReady,
                64'(if0.x), 64'(if0.y), if0.cIn, if0.sub, 64'(if0.s), if0.cOut, if0.ovf);
        observe(1, N1, W1, if1.inValid, if1.inReady, if1.outValid, if1.outReady,
                64'(if1.x), 64'(if1.y), if1.cIn, if1.sub, 64'(if1.s), if1.cOut, if1.ovf);
    endtask

    task automatic step0(input logic iv, input logic [W0-1:0] xa, input logic [W0-1:0] ya,
                         input logic ci, input logic sb, input logic ordy);
        @(negedge clk);
        if0.inValid  = iv;
        if0.x        = xa;
        if0.y        = ya;
        if0.cIn      = ci;
        if0.sub      = sb;
        if0.outReady = ordy;
        if1.inValid  = 1'b0;
        if1.outReady = 1'b1;
        #1;
        sample();
    endtask

    task automatic directed(input string tag, input logic [W0-1:0] xa, input logic [W0-1:0] ya,
                            input logic ci, input logic sb,
                            input logic [W0-1:0] es, input logic eco, input logic eov);
        int lat;
        lat = 0;
        step0(1'b1, xa, ya, ci, sb, 1'b1);
        do begin
            step0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat++;
        end while (!if0.outValid && lat < 10);
        chk({tag, "_lat"},  64'(lat), 64'(4));
        chk({tag, "_s"},    64'(if0.s), 64'(es));
        chk({tag, "_cOut"}, 64'(if0.cOut), 64'(eco));
        chk({tag, "_ovf"},  64'(if0.ovf), 64'(eov));
    endtask

    initial begin
        int sent, got, hold, seen;
        logic ordy, endchk;
        stalls[0] = 0;
        stalls[1] = 0;
        if0.inValid = 0; if0.x = '0; if0.y = '0; if0.cIn = 0; if0.sub = 0; if0.outReady = 1;
        if1.inValid = 0; if1.x = '0; if1.y = '0; if1.cIn = 0; if1.sub = 0; if1.outReady = 1;

        #2;
        chk("rst_outValid", 64'(if0.outValid), 64'(0));
        chk("rst_inReady",  64'(if0.inReady), 64'(1));
        chk("rst_s",        64'(if0.s), 64'(0));
        chk("rst_cOut",     64'(if0.cOut), 64'(0));
        chk("rst_ovf",      64'(if0.ovf), 64'(0));
        @(negedge clk);
        rstN = 1'b1;

        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_brw",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("add_cin",  16'h1234, 16'h0FCC, 1'b1, 1'b0, 16'h2201, 1'b0, 1'b0);

        // Eight back-to-back operations with a 3-cycle consumer stall after the 2nd result.
        sent = 0; got = 0; hold = 0; endchk = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            ordy = (hold == 0);
            step0(sent < 8, W0'($urandom), W0'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ordy);
            if (!ordy) begin
                chk("stall_inReady",  64'(if0.inReady), 64'(0));
                chk("stall_outValid", 64'(if0.outValid), 64'(1));
                chk("stall_s",        64'(if0.s), 64'(expq[0][0][W0-1:0]));
                chk("stall_cOut",     64'(if0.cOut), 64'(expq[0][0][64]));
                hold--;
                if (hold == 0) endchk = 1'b1;
            end else if (endchk) begin
                chk("stall_release_inReady", 64'(if0.inReady), 64'(1));
                endchk = 1'b0;
            end
            if (if0.inValid && if0.inReady) sent++;
            if (if0.outValid && if0.outReady) begin
                got++;
                if (got == 2) hold = 3;
            end
        end
        chk("stream_count", 64'(got), 64'(8));
        chk("stream_queue_empty", 64'(expq[0].size()), 64'(0));

        // Three operations in flight, first one parked at the output, then reset.
        for (int i = 0; i < 3; i++)
            step0(1'b1, W0'($urandom), W0'($urandom), 1'b0, 1'b0, 1'b0);
        step0(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step0(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("prerst_outValid", 64'(if0.outValid), 64'(1));
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_outValid", 64'(if0.outValid), 64'(0));
        chk("arst_s",        64'(if0.s), 64'(0));
        chk("arst_cOut",     64'(if0.cOut), 64'(0));
        chk("arst_inReady",  64'(if0.inReady), 64'(1));
        for (int d = 0; d < 2; d++) begin
            expq[d].delete();
            accq[d].delete();
            stq[d].delete();
        end
        @(negedge clk);
        #3;
        rstN = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (if0.outValid) seen++;
        end
        chk("rst_discarded", 64'(seen), 64'(0));
        directed("post_rst", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Random traffic on both instances with random source and sink pacing.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if0.inValid  = ($urandom_range(0, 3) != 0);
            if0.x        = W0'($urandom);
            if0.y        = W0'($urandom);
            if0.cIn      = 1'($urandom_range(0, 1));
            if0.sub      = 1'($urandom_range(0, 1));
            if0.outReady = ($urandom_range(0, 3) != 0);
            if1.inValid  = ($urandom_range(0, 3) != 0);
            if1.x        = W1'($urandom);
            if1.y        = W1'($urandom);
            if1.cIn      = 1'($urandom_range(0, 1));
            if1.sub      = 1'($urandom_range(0, 1));
            if1.outReady = ($urandom_range(0, 3) != 0);
            #1;
            sample();
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if0.inValid = 1'b0; if0.outReady = 1'b1;
            if1.inValid = 1'b0; if1.outReady = 1'b1;
            #1;
            sample();
        end
        chk("rand_d0_drained", 64'(expq[0].size()), 64'(0));
        chk("rand_d1_drained", 64'(expq[1].size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
